// File: rtl/vend_controller.sv
// vend_controller
//   Coin-path controller for the vending machine. Accumulates credit from
//   one coin per cycle, sequences a vend handshake once credit reaches
//   PRICE, then pays the remainder back as greedy change (quarter, dime,
//   nickel). A refund request before a vend commits returns the whole
//   credit the same way.
//
// Ports
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   coin_valid/coin_type : coin presented (0=5c, 1=10c, 2=25c, 3=100c)
//   coin_ready           : coin can be accepted this cycle
//   coin_reject          : one-cycle pulse, previous coin refused (overflow)
//   refunding            : refund request, level-sampled in COLLECT
//   vend / vend_ack      : vend request, held until acknowledged
//   change_valid/_coin   : change coin offered, held until change_ready
//   change_ready         : hopper took the offered coin
//   credit               : current credit in cents
module vend_controller #(
    parameter int unsigned PRICE      = 50,
    parameter int unsigned MAX_CREDIT = 200,
    parameter int unsigned CREDIT_W   = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                refunding,
    output logic                vend,
    input  logic                vend_ack,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit
);

    // One extra bit so credit + dollar can be compared against MAX_CREDIT
    // without wrapping.
    localparam int unsigned SW = CREDIT_W + 1;
    typedef logic [SW-1:0] sum_t;

    localparam sum_t PRICE_S = sum_t'(PRICE);
    localparam sum_t MAX_S   = sum_t'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    function automatic sum_t coin_val(input logic [1:0] t);
        case (t)
            2'd0:    return sum_t'(5);
            2'd1:    return sum_t'(10);
            2'd2:    return sum_t'(25);
            default: return sum_t'(100);
        endcase
    endfunction

    // Largest non-dollar coin not exceeding c. Credit is a multiple of 5,
    // so nickel is always a safe fallback for non-zero credit.
    function automatic logic [1:0] pick_change(input sum_t c);
        if (c >= sum_t'(25))      return 2'd2;
        else if (c >= sum_t'(10)) return 2'd1;
        else                      return 2'd0;
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                vend_q, vend_d;
    logic                cv_q, cv_d;
    logic [1:0]          coin_q, coin_d;

    sum_t sum, upd, rem;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        vend_d   = vend_q;
        cv_d     = cv_q;
        coin_d   = coin_q;
        sum      = {1'b0, credit_q} + coin_val(coin_type);
        upd      = {1'b0, credit_q};
        rem      = {1'b0, credit_q};

        case (state_q)
            S_COLLECT: begin
                if (coin_valid) begin
                    if (sum > MAX_S) reject_d = 1'b1;
                    else             upd      = sum;
                end
                credit_d = upd[CREDIT_W-1:0];
                // Exit decision uses the credit after this edge's coin;
                // refund takes priority over vend.
                if (refunding && upd != '0) begin
                    state_d = S_CHANGE;
                    cv_d    = 1'b1;
                    coin_d  = pick_change(upd);
                end else if (upd >= PRICE_S) begin
                    state_d = S_VEND;
                    vend_d  = 1'b1;
                end
            end
            S_VEND: begin
                if (vend_ack) begin
                    rem      = {1'b0, credit_q} - PRICE_S;
                    credit_d = rem[CREDIT_W-1:0];
                    vend_d   = 1'b0;
                    if (rem != '0) begin
                        state_d = S_CHANGE;
                        cv_d    = 1'b1;
                        coin_d  = pick_change(rem);
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_CHANGE: begin
                if (change_ready) begin
                    rem      = {1'b0, credit_q} - coin_val(coin_q);
                    credit_d = rem[CREDIT_W-1:0];
                    if (rem == '0) begin
                        state_d = S_COLLECT;
                        cv_d    = 1'b0;
                        coin_d  = 2'd0;
                    end else begin
                        coin_d  = pick_change(rem);
                    end
                end
            end
            default: begin
                state_d  = S_COLLECT;
                credit_d = '0;
                vend_d   = 1'b0;
                cv_d     = 1'b0;
                coin_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
            reject_q <= 1'b0;
            vend_q   <= 1'b0;
            cv_q     <= 1'b0;
            coin_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
            vend_q   <= vend_d;
            cv_q     <= cv_d;
            coin_q   <= coin_d;
        end
    end

    // Held low while reset is asserted, rises as soon as it is released.
    assign coin_ready   = reset_n && (state_q == S_COLLECT);
    assign coin_reject  = reject_q;
    assign vend         = vend_q;
    assign change_valid = cv_q;
    assign change_coin  = coin_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;

    localparam int PRICE = 50;
    localparam int MAXC  = 100;   // low enough that overflow is reachable
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_type = 2'd0;
    logic          coin_ready, coin_reject;
    logic          refunding = 1'b0;
    logic          vend;
    logic          vend_ack = 1'b0;
    logic          change_valid;
    logic [1:0]    change_coin;
    logic          change_ready = 1'b0;
    logic [CW-1:0] credit;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];   // expected change coins, in payout order

    vend_controller #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW)) dut (
        .clock(clk), .reset_n(rst_n),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_ready(coin_ready), .coin_reject(coin_reject),
        .refunding(refunding),
        .vend(vend), .vend_ack(vend_ack),
        .change_valid(change_valid), .change_coin(change_coin),
        .change_ready(change_ready),
        .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        change_ready = 1'b1;
        repeat (n) tick();
        change_ready = 1'b0;
    endtask

    // Scoreboard: every change handshake must match the next expected coin.
    always @(negedge clk) begin
        if (rst_n && change_valid && change_ready) begin
            chk("chg_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("chg_coin", int'(change_coin), exp_q.pop_front());
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_ready", int'(coin_ready), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_vend", int'(vend), 0);
        chk("rst_cv", int'(change_valid), 0);
        chk("rst_rej", int'(coin_reject), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", int'(coin_ready), 1);

        // Exact price: two quarters, stalled vend_ack
        insert(2'd2);
        chk("ex_c25", int'(credit), 25);
        chk("ex_novend", int'(vend), 0);
        insert(2'd2);
        chk("ex_c50", int'(credit), 50);
        chk("ex_vend", int'(vend), 1);
        chk("ex_busy", int'(coin_ready), 0);
        repeat (3) tick();
        chk("ex_hold", int'(vend), 1);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        chk("ex_c0", int'(credit), 0);
        chk("ex_vdone", int'(vend), 0);
        chk("ex_nocv", int'(change_valid), 0);
        chk("ex_ready", int'(coin_ready), 1);

        // Stray vend_ack / change_ready in COLLECT are ignored
        vend_ack = 1'b1; change_ready = 1'b1; tick();
        vend_ack = 1'b0; change_ready = 1'b0;
        chk("stray_credit", int'(credit), 0);
        chk("stray_ready", int'(coin_ready), 1);

        // Overpay with a dollar (sum == MAX_CREDIT is accepted)
        insert(2'd3);
        chk("op_c100", int'(credit), 100);
        chk("op_norej", int'(coin_reject), 0);
        chk("op_vend", int'(vend), 1);
        exp_q.push_back(2); exp_q.push_back(2);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        chk("op_c50", int'(credit), 50);
        chk("op_cv", int'(change_valid), 1);
        chk("op_coin", int'(change_coin), 2);
        tick();   // hopper stalls: offer must hold
        chk("op_stall_cv", int'(change_valid), 1);
        chk("op_stall_c", int'(credit), 50);
        drain(1);
        chk("op_c25", int'(credit), 25);
        drain(1);
        chk("op_c0", int'(credit), 0);
        chk("op_cvdone", int'(change_valid), 0);
        chk("op_ready", int'(coin_ready), 1);

        // Refund: dime + nickel
        insert(2'd1);
        insert(2'd0);
        chk("rf_c15", int'(credit), 15);
        exp_q.push_back(1); exp_q.push_back(0);
        refunding = 1'b1; tick(); refunding = 1'b0;
        chk("rf_cv", int'(change_valid), 1);
        chk("rf_coin", int'(change_coin), 1);
        chk("rf_novend", int'(vend), 0);
        drain(2);
        chk("rf_c0", int'(credit), 0);
        chk("rf_ready", int'(coin_ready), 1);
        chk("rf_novend2", int'(vend), 0);

        // Refund with zero credit has no effect
        refunding = 1'b1; tick(); refunding = 1'b0;
        chk("rz_cv", int'(change_valid), 0);
        chk("rz_ready", int'(coin_ready), 1);

        // Overflow: 25 + 10 + 100 > MAX_CREDIT
        insert(2'd2);
        insert(2'd1);
        insert(2'd3);
        chk("ov_rej", int'(coin_reject), 1);
        chk("ov_c35", int'(credit), 35);
        tick();
        chk("ov_rej_pulse", int'(coin_reject), 0);
        insert(2'd0);
        chk("ov_c40", int'(credit), 40);
        chk("ov_collect", int'(coin_ready), 1);
        chk("ov_novend", int'(vend), 0);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        refunding = 1'b1; tick(); refunding = 1'b0;
        drain(3);
        chk("ov_c0", int'(credit), 0);
        chk("ov_ready", int'(coin_ready), 1);

        // Simultaneous coin + refund: refund wins over vend
        insert(2'd2);
        exp_q.push_back(2); exp_q.push_back(2);
        coin_valid = 1'b1; coin_type = 2'd2; refunding = 1'b1;
        tick();
        coin_valid = 1'b0; refunding = 1'b0;
        chk("sim_c50", int'(credit), 50);
        chk("sim_cv", int'(change_valid), 1);
        chk("sim_novend", int'(vend), 0);
        drain(2);
        chk("sim_c0", int'(credit), 0);
        chk("sim_ready", int'(coin_ready), 1);

        // Reset mid-change
        insert(2'd3);
        vend_ack = 1'b1; tick(); vend_ack = 1'b0;
        chk("rm_cv", int'(change_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rm_credit", int'(credit), 0);
        chk("rm_cv0", int'(change_valid), 0);
        chk("rm_vend", int'(vend), 0);
        chk("rm_ready", int'(coin_ready), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rm_rel_ready", int'(coin_ready), 1);
        chk("rm_rel_credit", int'(credit), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
